// File: rtl/aes_pkg.sv
// Shared types and constants for the AES counter-mode sequencer.
// Imported by the interface, the increment helper and the top.
package aes_pkg;

    localparam int AES_BLOCK_W     = 128;
    localparam int CTR_WIDTH_DEF   = 32;
    localparam int AES_CTR_TIMEOUT = 255;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_ISSUE,
        ST_WAIT,
        ST_XOR,
        ST_OUT
    } ctr_state_e;

endpackage

// File: rtl/aes_ctr_ctrl_if.sv
// Request/response bus between the CTR sequencer and the AES core.
// master = sequencer side, slave = AES core side.
interface aes_ctr_ctrl_if;
    import aes_pkg::*;

    logic                   aes_on_o;
    logic                   aes_encdec_o;
    logic [AES_BLOCK_W-1:0] aes_key_o;
    logic [AES_BLOCK_W-1:0] aes_block_o;
    logic                   aes_ready_i;
    logic [AES_BLOCK_W-1:0] aes_result_i;
    logic                   aes_result_valid_i;

    modport master (
        output aes_on_o,
        output aes_encdec_o,
        output aes_key_o,
        output aes_block_o,
        input  aes_ready_i,
        input  aes_result_i,
        input  aes_result_valid_i
    );

    modport slave (
        input  aes_on_o,
        input  aes_encdec_o,
        input  aes_key_o,
        input  aes_block_o,
        output aes_ready_i,
        output aes_result_i,
        output aes_result_valid_i
    );

endinterface

// File: rtl/aes_ctr_inc.sv
// Counter-block increment: only the low CTR_WIDTH bits count and wrap;
// the nonce above them is passed through untouched, carry is dropped.
module aes_ctr_inc
    import aes_pkg::*;
#(
    parameter int CTR_WIDTH = CTR_WIDTH_DEF
) (
    input  logic [AES_BLOCK_W-1:0] blk,
    output logic [AES_BLOCK_W-1:0] nxt
);

    localparam logic [AES_BLOCK_W-1:0] MASK =
        {AES_BLOCK_W{1'b1}} >> (AES_BLOCK_W - CTR_WIDTH);

    logic [AES_BLOCK_W-1:0] sum;

    assign sum = blk + {{(AES_BLOCK_W-1){1'b0}}, 1'b1};
    assign nxt = (blk & ~MASK) | (sum & MASK);

endmodule

// File: rtl/aes_ctr_ctrl.sv
// AES-128 CTR sequencer: one core request per block, XOR with din.
// Optional watchdog on the core wait: define AES_CTR_TIMEOUT_EN.
module aes_ctr_ctrl
    import aes_pkg::*;
#(
    parameter int CTR_WIDTH = CTR_WIDTH_DEF
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   start_i,
    input  logic [AES_BLOCK_W-1:0] key_i,
    input  logic [AES_BLOCK_W-1:0] iv_i,
    input  logic [15:0]            num_blocks_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   err_o,
    input  logic                   din_valid_i,
    output logic                   din_ready_o,
    input  logic [AES_BLOCK_W-1:0] din_i,
    output logic                   dout_valid_o,
    input  logic                   dout_ready_i,
    output logic [AES_BLOCK_W-1:0] dout_o,
    aes_ctr_ctrl_if.master         aes
);

    ctr_state_e             state_q;
    ctr_state_e             state_d;
    logic [AES_BLOCK_W-1:0] key_q;
    logic [AES_BLOCK_W-1:0] ctr_q;
    logic [AES_BLOCK_W-1:0] ctr_nxt;
    logic [AES_BLOCK_W-1:0] ks_q;
    logic [AES_BLOCK_W-1:0] dout_q;
    logic [15:0]            rem_q;
    logic                   done_q;
    logic                   done_d;
    logic                   job_go;
    logic                   din_hs;

`ifdef AES_CTR_TIMEOUT_EN
    localparam logic [7:0] WD_LAST = 8'(AES_CTR_TIMEOUT - 1);
    logic [7:0] wd_q;
    logic       err_q;
    logic       err_d;
`endif

    assign job_go = (state_q == ST_IDLE) && start_i && (num_blocks_i != '0);
    assign din_hs = (state_q == ST_XOR) && din_valid_i;

    aes_ctr_inc #(
        .CTR_WIDTH (CTR_WIDTH)
    ) u_inc (
        .blk (ctr_q),
        .nxt (ctr_nxt)
    );

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and end-of-job pulses.
    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
`ifdef AES_CTR_TIMEOUT_EN
        err_d   = 1'b0;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    if (num_blocks_i != '0) begin
                        state_d = ST_REQ;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ST_REQ: begin
                if (aes.aes_ready_i) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (aes.aes_result_valid_i) begin
                    state_d = ST_XOR;
                end
`ifdef AES_CTR_TIMEOUT_EN
                else if (wd_q == WD_LAST) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                end
`endif
            end
            ST_XOR: begin
                if (din_valid_i) begin
                    state_d = ST_OUT;
                end
            end
            ST_OUT: begin
                if (dout_ready_i) begin
                    if (rem_q == '0) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_REQ;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Job registers: key/counter/count on start, keystream, output block.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            key_q  <= '0;
            ctr_q  <= '0;
            rem_q  <= '0;
            ks_q   <= '0;
            dout_q <= '0;
        end else begin
            if (job_go) begin
                key_q <= key_i;
                ctr_q <= iv_i;
                rem_q <= num_blocks_i;
            end
            if (state_q == ST_WAIT && aes.aes_result_valid_i) begin
                ks_q <= aes.aes_result_i;
            end
            if (din_hs) begin
                dout_q <= din_i ^ ks_q;
                ctr_q  <= ctr_nxt;
                rem_q  <= rem_q - 16'd1;
            end
        end
    end

    // Registered done pulse.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            done_q <= 1'b0;
        end else begin
            done_q <= done_d;
        end
    end

`ifdef AES_CTR_TIMEOUT_EN
    // Watchdog counts cycles spent in WAIT; error pulse rides with done.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
            if (state_q != ST_WAIT) begin
                wd_q <= '0;
            end else begin
                wd_q <= wd_q + 8'd1;
            end
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

    assign busy_o       = (state_q != ST_IDLE);
    assign done_o       = done_q;
    assign din_ready_o  = (state_q == ST_XOR);
    assign dout_valid_o = (state_q == ST_OUT);
    assign dout_o       = dout_q;

    assign aes.aes_on_o     = (state_q == ST_ISSUE);
    assign aes.aes_encdec_o = 1'b1;
    assign aes.aes_key_o    = key_q;
    assign aes.aes_block_o  = ctr_q;

endmodule

// File: doc/aes_ctr_ctrl.md
# aes_ctr_ctrl

Counter-mode sequencer that acts as the initiator on the AES core's request interface. It takes a key, an initial counter block and a block count, and issues one encipher request per block to the AES core. Each returned keystream block is XORed with an input data block, and the result is presented on an output stream. It sits between the bus-facing crypto registers or DMA and the AES core, so the core itself stays mode-agnostic.

## Interface
Parameters:
- CTR_WIDTH, 32: number of low-order bits of the counter block that increment; the upper 128-CTR_WIDTH bits are fixed nonce.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset; one clock; reset is asynchronous and active-low
- start_i  in  1  begin a job; sampled only in IDLE
- key_i  in  128  AES-128 key, latched on start
- iv_i  in  128  initial counter block, latched on start
- num_blocks_i  in  16  blocks in the job, latched on start
- busy_o  out  1  high whenever state is not IDLE
- done_o  out  1  one-cycle pulse at job end
- err_o  out  1  one-cycle pulse together with done_o on timeout abort
- din_valid_i / din_ready_o / din_i  in/out/in  1/1/128  input data stream
- dout_valid_o / dout_ready_i / dout_o  out/in/out  1/1/128  output data stream
- aes_on_o  out  1  request pulse to the AES core
- aes_encdec_o  out  1  constant 1 (encipher)
- aes_key_o  out  128  latched key
- aes_block_o  out  128  current counter block
- aes_ready_i  in  1  core idle
- aes_result_i  in  128  core result
- aes_result_valid_i  in  1  core result strobe, one cycle

## Operation
- FSM states: IDLE, REQ, ISSUE, WAIT, XOR, OUT.
- IDLE:
  - start_i with num_blocks_i != 0: latch key, counter and count, then go to REQ.
  - start_i with num_blocks_i == 0: done_o pulses next cycle, no core request, stay IDLE.
- REQ: wait for aes_ready_i = 1, then go to ISSUE.
- ISSUE: aes_on_o = 1 for exactly this cycle, then go to WAIT.
- WAIT: on aes_result_valid_i, capture aes_result_i into the keystream register and go to XOR. A strobe in any other state is ignored.
- XOR:
  - din_ready_o = 1.
  - On handshake: dout register gets din_i XOR keystream, counter increments, remaining count decrements, go to OUT.
- OUT:
  - dout_valid_o = 1; dout_o is held stable until the handshake.
  - On dout_ready_i: go to IDLE with a done_o pulse if remaining == 0, else go to REQ.
- Counter arithmetic:
  - Low CTR_WIDTH bits increment modulo 2^CTR_WIDTH.
  - Upper bits never change, including on wrap.
- aes_key_o and aes_block_o come straight from registers and are stable from ISSUE through WAIT.
- start_i while busy is ignored.
- Reset mid-job:
  - All registers clear immediately; state goes to IDLE.
  - aes_on_o, dout_valid_o, din_ready_o, done_o and err_o drop at once.
  - Any in-flight core result is discarded.

## Timing
- Reset values:
  - busy_o, done_o, err_o, din_ready_o, dout_valid_o and aes_on_o are 0.
  - aes_encdec_o is 1.
  - dout_o, aes_key_o and aes_block_o are 0.
- All outputs are registered or decoded from state only; no input-to-output combinational path except none.
- Cycle sequence, with start_i at cycle 0:
  - REQ at cycle 1.
  - With aes_ready_i high, ISSUE (aes_on_o) at cycle 2.
  - WAIT from cycle 3.
- Key-to-output latency = core latency + 4 cycles, excluding input and output stalls.
- done_o asserts the cycle after the final dout handshake; busy_o is low in that same cycle.

## Configuration
- AES_CTR_TIMEOUT_EN defined:
  - An 8-bit watchdog counts cycles in WAIT.
  - After 255 cycles without aes_result_valid_i, the job aborts: go to IDLE and pulse done_o and err_o together.
- Undefined: no watchdog; WAIT holds indefinitely; err_o is tied 0.

## Structure
- aes_pkg holds:
  - the FSM state enum typedef;
  - the AES_BLOCK_W = 128 constant;
  - the default CTR_WIDTH;
  - the AES_CTR_TIMEOUT = 255 constant.
- One sub-module: aes_ctr_inc, the masked increment of the low CTR_WIDTH bits.

## Test plan
- NIST SP800-38A F.5.1 check against the real AES core, 1 block:
  - key 2b7e151628aed2a6abf7158809cf4f3c, iv f0f1f2f3f4f5f6f7f8f9fafbfcfdfeff, din 6bc1bee22e409f96e93d7e117393172a.
  - Expect dout 874d6191b620e3261bef6864990db6ce, then done_o, err_o = 0.
- Counter wrap, 2 blocks, iv low 32 bits ffffffff:
  - Second aes_block_o has low 32 bits 00000000.
  - Upper 96 bits are unchanged.
- num_blocks_i = 0: aes_on_o never asserts; done_o pulses once at cycle 1.
- Backpressure:
  - dout_ready_i held low 10 cycles: dout_o is stable and no new aes_on_o is issued.
  - din_valid_i low for 5 cycles: FSM stays in XOR.
- Reset asserted during WAIT of block 2 of 3:
  - All outputs return to reset values asynchronously.
  - A later start_i runs a fresh job correctly.
- With AES_CTR_TIMEOUT_EN, stub core never strobes: done_o and err_o pulse 256 cycles after aes_on_o.
